eth_sync_bus_receiver: RTL and testbench
========================================

# eth_sync_bus_receiver

Receiving end of the four-phase req/ack bus crossing used in the Ethernet MAC 10/100. A transmitter in a foreign clock domain holds a data word stable and raises `req_in`. This block synchronizes `req_in` into `clk`, captures `din` into a small first-word-fall-through FIFO, and drives `ack_out` back across the boundary. When the FIFO is full, it withholds `ack_out`, which applies backpressure to the transmitter; consumers in the `clk` domain drain the FIFO through a valid/ready port.

## Interface
- `WIDTH`, 16, data word width (≥1)
- `DEPTH`, 4, FIFO entries; power of two, ≥2
- `SYNC`, 2, synchronizer stages on `req_in`; legal values 2 or 3
- `clk`  input  1  sole clock; all flops on rising edge
- `res`  input  1  asynchronous, active-high reset
- `req_in`  input  1  request from the foreign domain (asynchronous)
- `din`  input  WIDTH  data from the foreign domain; stable from `req_in` rise until `ack_out` rise
- `ack_out`  output  1  acknowledge to the foreign domain; driven directly from a flop
- `dout`  output  WIDTH  FIFO head word
- `dout_valid`  output  1  FIFO non-empty
- `dout_ready`  input  1  consumer pops the head when `dout_valid` && `dout_ready`
- `level`  output  $clog2(DEPTH)+1  current FIFO occupancy, range 0..DEPTH
- `xfer_cnt`  output  16  count of captured words; wraps from 0xFFFF to 0

## Operation
- Synchronizer: a chain of `SYNC` flops on `req_in`, reset to 0. `req_s` is the last stage.
- FSM states: IDLE, ACKED. Reset state is IDLE.
- IDLE, `req_s`=1, not full (`level` < DEPTH):
  - write `din` at the write pointer;
  - set `ack_out`=1;
  - increment `xfer_cnt`;
  - go to ACKED.
- IDLE, `req_s`=1, full: stay in IDLE with `ack_out`=0. Capture happens on the first cycle the registered `level` is below DEPTH.
- IDLE, `req_s`=0: no action.
- ACKED, `req_s`=1: hold `ack_out`=1.
- ACKED, `req_s`=0: clear `ack_out`, go to IDLE.
- Exactly one word is written per `req_in` high phase. A new capture requires `req_s` to return to 0 and then rise again.
- FIFO:
  - `dout` = mem[rd_ptr]; `dout_valid` = (`level` != 0).
  - Pop on `dout_valid` && `dout_ready`.
  - `dout_ready` while empty is ignored.
  - Pointers are $clog2(DEPTH) bits and wrap modulo DEPTH.
- Simultaneous write and pop: both take effect and `level` is unchanged. This applies when not empty; at `level`=0 no pop occurs. A pop while full does not allow a capture in the same cycle, because the full check uses the registered `level`.
- `din` is sampled only in the capture cycle. No flop samples `din` at any other time.
- Data in memory is not reset; only pointers, `level`, the FSM and counters are reset.

## Timing
- Reset values: `ack_out`=0, `dout_valid`=0, `level`=0, `xfer_cnt`=0, synchronizer=0, FSM=IDLE. `dout` is don't-care while `dout_valid`=0.
- Request to acknowledge:
  - `req_in` is first sampled high at edge N;
  - `req_s`=1 after edge N+SYNC-1;
  - capture occurs at edge N+SYNC;
  - `ack_out`=1 and `dout_valid`=1 from edge N+SYNC onward, when not full.
- Acknowledge release: `ack_out` falls SYNC+1 edges after `req_in` is first sampled low.
- Pop: `level` decrements and the head advances on the same edge that samples `dout_valid` && `dout_ready`.
- Full stall: capture occurs one edge after the pop that brings `level` from DEPTH to DEPTH-1.
- Reset mid-transfer:
  - `ack_out` drops immediately (asynchronous) and the FIFO empties.
  - If `req_in` is still high after reset deasserts, it is treated as a fresh request and captured after SYNC+1 edges.
- Throughput: a full handshake costs at least 2·(SYNC+1) `clk` edges plus the foreign-side synchronizer latency.

## Test plan
- Single transfer, WIDTH=16, SYNC=2:
  - stimulus: `din`=0x0004, raise `req_in`, `dout_ready`=0;
  - response: `ack_out` rises 3 edges after first high sample, `dout`=0x0004, `level`=1, `xfer_cnt`=1;
  - stimulus: drop `req_in`;
  - response: `ack_out` falls 3 edges later.
- Back-to-back burst of 0x0011, 0x0022, 0x0033 with `dout_ready`=1: `dout` presents them in order, no duplicates, `xfer_cnt`=3, `level` ends at 0.
- Backpressure:
  - stimulus: DEPTH=4, 5 handshakes with `dout_ready`=0;
  - response: `level`=4 and `ack_out` stays 0 for the 5th;
  - stimulus: pulse `dout_ready` for one cycle;
  - response: 5th word captured one edge after the pop, `level`=4.
- Long hold: `req_in` held high for 20 cycles → exactly one word captured and `ack_out` high throughout ACKED.
- Pointer wrap and counter: with DEPTH=4 and SYNC=3, run 10 transfers with random `dout_ready`; ordering is preserved across the wrap and `level` never exceeds 4. Preload `xfer_cnt`=0xFFFF (force) and one transfer → `xfer_cnt`=0.
- Reset mid-transfer:
  - stimulus: assert `res` in ACKED with `level`=2;
  - response: `ack_out`=0, `level`=0, `dout_valid`=0 immediately;
  - stimulus: keep `req_in` high through reset release;
  - response: recapture after SYNC+1 edges, `level`=1.

Source files
------------

// File: rtl/eth_sync_bus_receiver.sv
// Receiving side of the four-phase req/ack bus crossing: synchronizes req_in,
// captures din into a small first-word-fall-through FIFO and withholds ack_out while full.
module eth_sync_bus_receiver #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 4,
  parameter int SYNC  = 2
) (
  input  logic                   clk,
  input  logic                   res,
  input  logic                   req_in,
  input  logic [WIDTH-1:0]       din,
  output logic                   ack_out,
  output logic [WIDTH-1:0]       dout,
  output logic                   dout_valid,
  input  logic                   dout_ready,
  output logic [$clog2(DEPTH):0] level,
  output logic [15:0]            xfer_cnt
);
  localparam int PW = $clog2(DEPTH);
  localparam int LW = PW + 1;
  localparam logic [LW-1:0] FULL_LVL = LW'(DEPTH);

  localparam logic [0:0] IDLE  = 1'b0;
  localparam logic [0:0] ACKED = 1'b1;

  logic [SYNC-1:0]  sync_q, sync_d;
  logic [0:0]       state_q, state_d;
  logic             ack_q, ack_d;
  logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [LW-1:0]    level_q, level_d;
  logic [15:0]      xfer_cnt_q, xfer_cnt_d;
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic             req_s;
  logic             wr_en;
  logic             pop;
  logic             not_empty;

  assign req_s     = sync_q[SYNC-1];
  assign not_empty = (level_q != '0);
  assign pop       = not_empty && dout_ready;

  always_comb begin
    sync_d     = {sync_q[SYNC-2:0], req_in};
    state_d    = state_q;
    ack_d      = ack_q;
    wr_en      = 1'b0;
    // Full check uses the registered level, so a pop cannot free space for the same edge.
    case (state_q)
      IDLE: begin
        if (req_s && (level_q < FULL_LVL)) begin
          wr_en   = 1'b1;
          ack_d   = 1'b1;
          state_d = ACKED;
        end
      end
      ACKED: begin
        if (!req_s) begin
          ack_d   = 1'b0;
          state_d = IDLE;
        end
      end
      default: begin
        ack_d   = 1'b0;
        state_d = IDLE;
      end
    endcase

    wr_ptr_d   = wr_en ? wr_ptr_q + PW'(1) : wr_ptr_q;
    rd_ptr_d   = pop ? rd_ptr_q + PW'(1) : rd_ptr_q;
    xfer_cnt_d = wr_en ? xfer_cnt_q + 16'd1 : xfer_cnt_q;

    case ({wr_en, pop})
      2'b10:   level_d = level_q + LW'(1);
      2'b01:   level_d = level_q - LW'(1);
      default: level_d = level_q;
    endcase
  end

  always_ff @(posedge clk or posedge res) begin
    if (res) begin
      sync_q     <= '0;
      state_q    <= IDLE;
      ack_q      <= 1'b0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      level_q    <= '0;
      xfer_cnt_q <= '0;
    end else begin
      sync_q     <= sync_d;
      state_q    <= state_d;
      ack_q      <= ack_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      level_q    <= level_d;
      xfer_cnt_q <= xfer_cnt_d;
    end
  end

  // Storage is deliberately left out of reset; din is only sampled on a capture.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem_q[wr_ptr_q] <= din;
    end
  end

  assign ack_out    = ack_q;
  assign dout       = mem_q[rd_ptr_q];
  assign dout_valid = not_empty;
  assign level      = level_q;
  assign xfer_cnt   = xfer_cnt_q;

endmodule

// File: tb/tb_eth_sync_bus_receiver.sv
// Bench for eth_sync_bus_receiver: a foreign-side four-phase transmitter, a
// (optionally random) consumer and a queue holding the expected FIFO contents.
`timescale 1ns/1ps
module tb_eth_sync_bus_receiver;
  localparam int W  = 16;
  localparam int D  = 4;
  localparam int LW = $clog2(D) + 1;

  logic          clk = 1'b0;
  logic          res;
  logic          req;
  logic          rdy;
  logic [W-1:0]  din;
  logic          ack2, ack3, val2, val3;
  logic [W-1:0]  dout2, dout3;
  logic [LW-1:0] lvl2, lvl3;
  logic [15:0]   cnt2, cnt3;

  always #5 clk = ~clk;

  eth_sync_bus_receiver #(.WIDTH(W), .DEPTH(D), .SYNC(2)) dut (
    .clk(clk), .res(res), .req_in(req), .din(din), .ack_out(ack2),
    .dout(dout2), .dout_valid(val2), .dout_ready(rdy), .level(lvl2), .xfer_cnt(cnt2)
  );

  eth_sync_bus_receiver #(.WIDTH(W), .DEPTH(D), .SYNC(3)) dut3 (
    .clk(clk), .res(res), .req_in(req), .din(din), .ack_out(ack3),
    .dout(dout3), .dout_valid(val3), .dout_ready(rdy), .level(lvl3), .xfer_cnt(cnt3)
  );

  // sel chooses which instance the tasks observe (0: SYNC=2, 1: SYNC=3).
  bit            sel = 1'b0;
  logic          ack, val;
  logic [W-1:0]  dout;
  logic [LW-1:0] lvl;
  logic [15:0]   cnt;
  assign ack  = sel ? ack3  : ack2;
  assign val  = sel ? val3  : val2;
  assign dout = sel ? dout3 : dout2;
  assign lvl  = sel ? lvl3  : lvl2;
  assign cnt  = sel ? cnt3  : cnt2;

  int           checks = 0;
  int           errors = 0;
  logic [W-1:0] mq[$];
  logic [W-1:0] obs[$];
  int           mcnt;
  bit           rand_rdy;
  int           max_lvl;

  // One clock: consumer decision, edge, then update of the expected FIFO contents.
  task automatic step();
    bit   will_pop;
    logic prev_ack;
    if (rand_rdy) rdy = 1'($urandom_range(0, 1));
    will_pop = (mq.size() != 0) && (rdy == 1'b1);
    prev_ack = ack;
    if (will_pop) obs.push_back(dout);
    @(posedge clk);
    @(negedge clk);
    if (will_pop) mq.delete(0);
    if (ack === 1'b1 && prev_ack !== 1'b1) begin
      mq.push_back(din);
      mcnt = (mcnt + 1) % 65536;
    end
    if (int'(lvl) > max_lvl) max_lvl = int'(lvl);
  endtask

  task automatic send(input logic [W-1:0] word, output int lat_r, output int lat_f);
    din = word;
    req = 1'b1;
    lat_r = 0;
    do begin step(); lat_r++; end while (ack !== 1'b1 && lat_r < 200);
    checks++; if (ack !== 1'b1) begin errors++; $display("FAIL send_ack_rise: ack=%b after %0d cycles, required 1 (word %h)", ack, lat_r, word); end
    req = 1'b0;
    lat_f = 0;
    do begin step(); lat_f++; end while (ack !== 1'b0 && lat_f < 200);
    checks++; if (ack !== 1'b0) begin errors++; $display("FAIL send_ack_fall: ack=%b after %0d cycles, required 0 (word %h)", ack, lat_f, word); end
  endtask

  task automatic do_reset();
    res = 1'b1; req = 1'b0; rdy = 1'b0; rand_rdy = 1'b0; din = '0;
    @(posedge clk); @(negedge clk);
    @(posedge clk); @(negedge clk);
    res = 1'b0;
    mq.delete(); obs.delete(); mcnt = 0; max_lvl = 0;
  endtask

  task automatic test_reset();
    sel = 1'b0; req = 1'b0; rdy = 1'b0; rand_rdy = 1'b0; din = '0;
    res = 1'b1;
    #1;
    checks++; if (ack !== 1'b0)   begin errors++; $display("FAIL reset_ack: got %b, required 0", ack); end
    checks++; if (val !== 1'b0)   begin errors++; $display("FAIL reset_valid: got %b, required 0", val); end
    checks++; if (lvl !== 3'd0)   begin errors++; $display("FAIL reset_level: got %0d, required 0", lvl); end
    checks++; if (cnt !== 16'h0)  begin errors++; $display("FAIL reset_cnt: got %h, required 0000", cnt); end
    checks++; if (ack3 !== 1'b0 || lvl3 !== 3'd0) begin errors++; $display("FAIL reset_sync3: ack=%b level=%0d, required 0/0", ack3, lvl3); end
    @(negedge clk);
    do_reset();
    repeat (4) step();
    checks++; if (ack !== 1'b0 || val !== 1'b0) begin errors++; $display("FAIL idle_after_reset: ack=%b valid=%b, required 0/0", ack, val); end
  endtask

  task automatic test_single();
    int lr, lf;
    sel = 1'b0; do_reset();
    send(16'h0004, lr, lf);
    checks++; if (lr != 3)         begin errors++; $display("FAIL single_rise_latency: got %0d, required 3", lr); end
    checks++; if (lf != 3)         begin errors++; $display("FAIL single_fall_latency: got %0d, required 3", lf); end
    checks++; if (dout !== 16'h0004) begin errors++; $display("FAIL single_dout: got %h, required 0004", dout); end
    checks++; if (val !== 1'b1)    begin errors++; $display("FAIL single_valid: got %b, required 1", val); end
    checks++; if (lvl !== 3'd1)    begin errors++; $display("FAIL single_level: got %0d, required 1", lvl); end
    checks++; if (cnt !== 16'd1)   begin errors++; $display("FAIL single_cnt: got %0d, required 1", cnt); end
    rdy = 1'b1; step(); rdy = 1'b0;
    checks++; if (lvl !== 3'd0 || val !== 1'b0) begin errors++; $display("FAIL single_pop: level=%0d valid=%b, required 0/0", lvl, val); end
    checks++; if (obs.size() != 1 || obs[0] !== 16'h0004) begin errors++; $display("FAIL single_popped: got %0d words, required one 0004", obs.size()); end
  endtask

  task automatic test_back_to_back();
    logic [W-1:0] exp_w[3];
    int lr, lf;
    sel = 1'b0; do_reset();
    exp_w[0] = 16'h0011; exp_w[1] = 16'h0022; exp_w[2] = 16'h0033;
    rdy = 1'b1;
    for (int i = 0; i < 3; i++) send(exp_w[i], lr, lf);
    repeat (3) step();
    checks++; if (obs.size() != 3) begin errors++; $display("FAIL b2b_count: got %0d words, required 3", obs.size()); end
    for (int i = 0; i < 3 && i < obs.size(); i++) begin
      checks++; if (obs[i] !== exp_w[i]) begin errors++; $display("FAIL b2b_word%0d: got %h, required %h", i, obs[i], exp_w[i]); end
    end
    checks++; if (cnt !== 16'd3) begin errors++; $display("FAIL b2b_cnt: got %0d, required 3", cnt); end
    checks++; if (lvl !== 3'd0)  begin errors++; $display("FAIL b2b_level: got %0d, required 0", lvl); end
  endtask

  task automatic test_backpressure();
    logic [W-1:0] w[5];
    int lr, lf, ack_hi, n;
    sel = 1'b0; do_reset();
    for (int i = 0; i < 5; i++) w[i] = W'($urandom);
    for (int i = 0; i < 4; i++) send(w[i], lr, lf);
    checks++; if (lvl !== 3'd4) begin errors++; $display("FAIL bp_full_level: got %0d, required 4", lvl); end
    din = w[4]; req = 1'b1; ack_hi = 0;
    repeat (10) begin step(); if (ack !== 1'b0) ack_hi++; end
    checks++; if (ack_hi != 0)  begin errors++; $display("FAIL bp_ack_withheld: ack high %0d cycles, required 0", ack_hi); end
    checks++; if (cnt !== 16'd4) begin errors++; $display("FAIL bp_cnt_stalled: got %0d, required 4", cnt); end
    rdy = 1'b1; step(); rdy = 1'b0;
    checks++; if (ack !== 1'b0 || lvl !== 3'd3) begin errors++; $display("FAIL bp_pop_edge: ack=%b level=%0d, required 0/3", ack, lvl); end
    step();
    checks++; if (ack !== 1'b1 || lvl !== 3'd4) begin errors++; $display("FAIL bp_capture_edge: ack=%b level=%0d, required 1/4", ack, lvl); end
    req = 1'b0; n = 0;
    do begin step(); n++; end while (ack !== 1'b0 && n < 50);
    checks++; if (cnt !== 16'd5) begin errors++; $display("FAIL bp_cnt: got %0d, required 5", cnt); end
    rdy = 1'b1; repeat (6) step(); rdy = 1'b0;
    checks++; if (obs.size() != 5) begin errors++; $display("FAIL bp_count: got %0d words, required 5", obs.size()); end
    for (int i = 0; i < 5 && i < obs.size(); i++) begin
      checks++; if (obs[i] !== w[i]) begin errors++; $display("FAIL bp_word%0d: got %h, required %h", i, obs[i], w[i]); end
    end
  endtask

  task automatic test_long_hold();
    logic [W-1:0] w;
    int n, low;
    sel = 1'b0; do_reset();
    w = W'($urandom); din = w; req = 1'b1; n = 0;
    do begin step(); n++; end while (ack !== 1'b1 && n < 50);
    low = 0;
    repeat (20) begin din = W'($urandom); step(); if (ack !== 1'b1) low++; end
    checks++; if (low != 0)       begin errors++; $display("FAIL hold_ack: low %0d cycles, required 0", low); end
    checks++; if (lvl !== 3'd1)   begin errors++; $display("FAIL hold_level: got %0d, required 1", lvl); end
    checks++; if (cnt !== 16'd1)  begin errors++; $display("FAIL hold_cnt: got %0d, required 1", cnt); end
    checks++; if (dout !== w)     begin errors++; $display("FAIL hold_dout: got %h, required %h", dout, w); end
    req = 1'b0; n = 0;
    do begin step(); n++; end while (ack !== 1'b0 && n < 50);
    checks++; if (lvl !== 3'd1 || ack !== 1'b0) begin errors++; $display("FAIL hold_release: level=%0d ack=%b, required 1/0", lvl, ack); end
  endtask

  task automatic test_wrap();
    logic [W-1:0] sent[$];
    logic [W-1:0] w;
    int lr, lf, short_lat, n;
    sel = 1'b1; do_reset();
    rand_rdy = 1'b1; short_lat = 0;
    for (int i = 0; i < 10; i++) begin
      w = W'($urandom); sent.push_back(w);
      send(w, lr, lf);
      if (lr < 4 || lf != 4) short_lat++;
    end
    rand_rdy = 1'b0; rdy = 1'b1; n = 0;
    while (mq.size() != 0 && n < 20) begin step(); n++; end
    step(); rdy = 1'b0;
    checks++; if (short_lat != 0)  begin errors++; $display("FAIL wrap_latency: %0d handshakes off, required 0", short_lat); end
    checks++; if (obs.size() != 10) begin errors++; $display("FAIL wrap_count: got %0d words, required 10", obs.size()); end
    for (int i = 0; i < 10 && i < obs.size(); i++) begin
      checks++; if (obs[i] !== sent[i]) begin errors++; $display("FAIL wrap_word%0d: got %h, required %h", i, obs[i], sent[i]); end
    end
    checks++; if (max_lvl > 4)      begin errors++; $display("FAIL wrap_max_level: got %0d, required <= 4", max_lvl); end
    checks++; if (cnt !== 16'(mcnt)) begin errors++; $display("FAIL wrap_cnt: got %0d, required %0d", cnt, mcnt); end
    checks++; if (lvl !== 3'd0 || val !== 1'b0) begin errors++; $display("FAIL wrap_drained: level=%0d valid=%b, required 0/0", lvl, val); end
    sel = 1'b0;
  endtask

  task automatic test_cnt_wrap();
    int lr, lf;
    sel = 1'b0; do_reset();
    force dut.xfer_cnt_q = 16'hFFFF;
    step();
    release dut.xfer_cnt_q;
    checks++; if (cnt !== 16'hFFFF) begin errors++; $display("FAIL cnt_preload: got %h, required ffff", cnt); end
    send(W'($urandom), lr, lf);
    checks++; if (cnt !== 16'h0000) begin errors++; $display("FAIL cnt_wrap: got %h, required 0000", cnt); end
  endtask

  task automatic test_reset_mid();
    logic [W-1:0] w1, w2;
    int lr, lf, n;
    sel = 1'b0; do_reset();
    w1 = W'($urandom); w2 = W'($urandom);
    send(w1, lr, lf);
    din = w2; req = 1'b1; n = 0;
    do begin step(); n++; end while (ack !== 1'b1 && n < 50);
    checks++; if (lvl !== 3'd2) begin errors++; $display("FAIL mid_pre_level: got %0d, required 2", lvl); end
    res = 1'b1;
    #1;
    checks++; if (ack !== 1'b0) begin errors++; $display("FAIL mid_ack_async: got %b, required 0", ack); end
    checks++; if (lvl !== 3'd0) begin errors++; $display("FAIL mid_level_async: got %0d, required 0", lvl); end
    checks++; if (val !== 1'b0) begin errors++; $display("FAIL mid_valid_async: got %b, required 0", val); end
    mq.delete(); obs.delete(); mcnt = 0;
    @(posedge clk); @(negedge clk);
    res = 1'b0; n = 0;
    do begin step(); n++; end while (ack !== 1'b1 && n < 50);
    checks++; if (n != 3)        begin errors++; $display("FAIL mid_recapture_latency: got %0d, required 3", n); end
    checks++; if (lvl !== 3'd1)  begin errors++; $display("FAIL mid_recapture_level: got %0d, required 1", lvl); end
    checks++; if (dout !== w2)   begin errors++; $display("FAIL mid_recapture_dout: got %h, required %h", dout, w2); end
    checks++; if (cnt !== 16'd1) begin errors++; $display("FAIL mid_recapture_cnt: got %0d, required 1", cnt); end
    req = 1'b0; n = 0;
    do begin step(); n++; end while (ack !== 1'b0 && n < 50);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    res = 1'b0; req = 1'b0; rdy = 1'b0; din = '0; rand_rdy = 1'b0;
    mcnt = 0; max_lvl = 0;
    test_reset();
    test_single();
    test_back_to_back();
    test_backpressure();
    test_long_hold();
    test_wrap();
    test_cnt_wrap();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
